pc_fetch_unit: RTL and testbench

- Receiving end of the branch-resolution interface: holds the program counter, fetches instruction words from instruction memory, and applies redirects from the branch unit (shouldUseNewPC/branchTo).
- Supplies pcAddress (issued instruction address + 4) back to the branch unit for relative-offset computation.
- Sits between instruction memory and decode. Squashes in-flight fetches on redirect.

---
 rtl/pc_fetch_unit.sv | 158 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: owns the program counter, fetches from instruction memory,
// presents words to decode and applies branch-unit redirects.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          SQUASH_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shouldUseNewPC,
  input  logic [31:0]             branchTo,
  output logic                    fetchValid,
  output logic [31:0]             fetchAddress,
  input  logic                    fetchReady,
  input  logic                    fetchDataValid,
  input  logic [31:0]             fetchData,
  output logic                    instrValid,
  output logic [31:0]             instruction,
  output logic [31:0]             instrAddress,
  input  logic                    instrAccept,
  output logic [31:0]             pcAddress,
  output logic                    addressError,
  output logic [SQUASH_CNT_W-1:0] squashCount
);

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WAIT_DATA,
    ISSUE,
    FAULT
  } state_t;

  state_t                  state;
  state_t                  nstate;
  logic [31:0]             pc;
  logic [31:0]             npc;
  logic [31:0]             ia_q;
  logic [31:0]             ins_q;
  logic                    squash;
  logic                    nsquash;
  logic                    bump;
  logic                    latch;
  logic                    fv_q;
  logic                    iv_q;
  logic                    err_q;
  logic [SQUASH_CNT_W-1:0] scnt;
  logic                    misaligned;

  assign misaligned = shouldUseNewPC && (branchTo[1:0] != 2'b00);

  always_comb begin
    nstate  = state;
    npc     = pc;
    nsquash = squash;
    bump    = 1'b0;
    latch   = 1'b0;
    unique case (state)
      IDLE: begin
        nstate = REQUEST;
        if (shouldUseNewPC)
          npc = branchTo;
      end
      REQUEST: begin
        if (shouldUseNewPC) begin
          npc = branchTo;
          if (fetchReady) begin
            nstate  = WAIT_DATA;
            nsquash = 1'b1;
            bump    = 1'b1;
          end
        end else if (fetchReady) begin
          nstate = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (shouldUseNewPC) begin
          npc  = branchTo;
          // one outstanding response, so only the first redirect counts
          bump = !squash;
          if (fetchDataValid) begin
            nstate  = REQUEST;
            nsquash = 1'b0;
          end else begin
            nsquash = 1'b1;
          end
        end else if (fetchDataValid) begin
          if (squash) begin
            nstate  = REQUEST;
            nsquash = 1'b0;
          end else begin
            nstate = ISSUE;
            latch  = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (shouldUseNewPC) begin
          npc    = branchTo;
          nstate = REQUEST;
          bump   = 1'b1;
        end else if (instrAccept) begin
          npc    = pc + 32'd4;
          nstate = REQUEST;
        end
      end
      FAULT: begin
        nstate = FAULT;
      end
      default: begin
        nstate = IDLE;
      end
    endcase
    if (misaligned && state != FAULT) begin
      nstate  = FAULT;
      npc     = pc;
      nsquash = 1'b0;
      bump    = 1'b0;
      latch   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pc     <= RESET_VECTOR;
      squash <= 1'b0;
      fv_q   <= 1'b0;
      iv_q   <= 1'b0;
      err_q  <= 1'b0;
      ia_q   <= RESET_VECTOR;
      ins_q  <= '0;
      scnt   <= '0;
    end else begin
      state  <= nstate;
      pc     <= npc;
      squash <= nsquash;
      fv_q   <= (nstate == REQUEST);
      iv_q   <= (nstate == ISSUE);
      err_q  <= err_q | (nstate == FAULT);
      if (latch) begin
        ins_q <= fetchData;
        ia_q  <= pc;
      end
      if (bump && !(&scnt))
        scnt <= scnt + 1'b1;
    end
  end

  assign fetchValid   = fv_q;
  assign fetchAddress = pc;
  assign instrValid   = iv_q;
  assign instruction  = iv_q ? ins_q : 32'h0;
  assign instrAddress = iv_q ? ia_q : 32'h0;
  assign pcAddress    = ia_q + 32'd4;
  assign addressError = err_q;
  assign squashCount  = scnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: behavioural memory for the default
// instance, hand-driven memory for a wrap-around reset-vector instance.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, rdr, fr, fdv, acc;
  logic [31:0] bt, fd;
  logic        fv, iv, err;
  logic [31:0] fa, ins, ia, pca;
  logic [15:0] sq;

  logic        rst2, rdr2, fr2, fdv2, acc2;
  logic [31:0] bt2, fd2;
  logic        fv2, iv2, err2;
  logic [31:0] fa2, ins2, ia2, pca2;
  logic [15:0] sq2;

  int          lat;
  logic        dbf;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst),
    .shouldUseNewPC(rdr), .branchTo(bt),
    .fetchValid(fv), .fetchAddress(fa), .fetchReady(fr),
    .fetchDataValid(fdv), .fetchData(fd),
    .instrValid(iv), .instruction(ins), .instrAddress(ia),
    .instrAccept(acc), .pcAddress(pca),
    .addressError(err), .squashCount(sq)
  );

  pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2),
    .shouldUseNewPC(rdr2), .branchTo(bt2),
    .fetchValid(fv2), .fetchAddress(fa2), .fetchReady(fr2),
    .fetchDataValid(fdv2), .fetchData(fd2),
    .instrValid(iv2), .instruction(ins2), .instrAddress(ia2),
    .instrAccept(acc2), .pcAddress(pca2),
    .addressError(err2), .squashCount(sq2)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return dbf ? 32'hDEAD_BEEF : (a ^ 32'h0000_1300);
  endfunction

  // one response per handoff, lat cycles after it
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= 1'b0;
      cnt  <= 0;
      fdv  <= 1'b0;
      fd   <= 32'h0;
    end else begin
      fdv <= 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          fdv  <= 1'b1;
          fd   <= word(paddr);
          pend <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (fv && fr) begin
        paddr <= fa;
        if (lat <= 1) begin
          fdv <= 1'b1;
          fd  <= word(fa);
        end else begin
          pend <= 1'b1;
          cnt  <= lat - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    logic seen;
    rst = 0; rdr = 0; bt = 0; fr = 1; acc = 1; lat = 1; dbf = 0;
    rst2 = 0; rdr2 = 0; bt2 = 0; fr2 = 1; fdv2 = 0; fd2 = 0; acc2 = 1;
    tick(); tick();
    chk("rst_fv", fv, 0);
    chk("rst_fa", fa, 0);
    chk("rst_pca", pca, 32'h4);
    chk("rst_iv", iv, 0);
    chk("rst_ia", ia, 0);
    chk("rst_sq", sq, 0);
    chk("rst_err", err, 0);

    rst = 1;
    tick();
    chk("f0_fv", fv, 1);
    chk("f0_fa", fa, 0);
    tick();
    chk("w0_fv", fv, 0);
    chk("w0_iv", iv, 0);
    tick();
    chk("i0_iv", iv, 1);
    chk("i0_ia", ia, 0);
    chk("i0_pca", pca, 32'h4);
    chk("i0_ins", ins, 32'h0000_1300);
    tick();
    chk("f1_fv", fv, 1);
    chk("f1_fa", fa, 32'h4);
    tick(); tick();
    chk("i1_iv", iv, 1);
    chk("i1_ia", ia, 32'h4);
    chk("i1_pca", pca, 32'h8);
    tick();
    chk("f2_fa", fa, 32'h8);
    tick(); tick();
    chk("i2_iv", iv, 1);
    chk("i2_ia", ia, 32'h8);

    // redirect with simultaneous accept
    rdr = 1; bt = 32'h100;
    tick();
    rdr = 0;
    chk("ri_iv", iv, 0);
    chk("ri_fv", fv, 1);
    chk("ri_fa", fa, 32'h100);
    chk("ri_sq", sq, 1);

    // redirect while waiting, slow response discarded
    lat = 3; dbf = 1;
    tick();
    chk("rw_wait", fv, 0);
    rdr = 1; bt = 32'h200;
    tick();
    rdr = 0;
    chk("rw_sq", sq, 2);
    chk("rw_fv", fv, 0);
    found = 0; seen = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (iv) seen = 1;
      if (fv) found = 1;
    end
    dbf = 0;
    chk("rw_found", found, 1);
    chk("rw_noiss", seen, 0);
    chk("rw_fa", fa, 32'h200);
    chk("rw_sq2", sq, 2);

    // two redirects, one outstanding fetch
    tick();
    rdr = 1; bt = 32'h300;
    tick();
    bt = 32'h400;
    tick();
    rdr = 0;
    found = 0; seen = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (iv) seen = 1;
      if (fv) found = 1;
    end
    chk("r2_found", found, 1);
    chk("r2_noiss", seen, 0);
    chk("r2_fa", fa, 32'h400);
    chk("r2_sq", sq, 3);
    lat = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (iv) found = 1;
    end
    chk("r2_iv", found, 1);
    chk("r2_ia", ia, 32'h400);
    chk("r2_ins", ins, 32'h0000_1700);

    // misaligned redirect
    rdr = 1; bt = 32'h102;
    tick();
    rdr = 0;
    chk("mf_err", err, 1);
    chk("mf_fv", fv, 0);
    chk("mf_iv", iv, 0);
    seen = 0;
    repeat (4) begin
      tick();
      if (fv) seen = 1;
    end
    chk("mf_nofv", seen, 0);
    chk("mf_err2", err, 1);
    chk("mf_sq", sq, 3);
    rst = 0;
    #1;
    chk("mr_err", err, 0);
    chk("mr_fa", fa, 0);
    chk("mr_sq", sq, 0);
    tick();
    rst = 1;
    tick();
    chk("mr_fv", fv, 1);
    chk("mr_fa2", fa, 0);

    // wrap-around reset vector
    chk("w_rst_fa", fa2, 32'hFFFF_FFFC);
    chk("w_rst_pca", pca2, 32'h0);
    chk("w_rst_fv", fv2, 0);
    chk("w_rst_iv", iv2, 0);
    rst2 = 1;
    tick();
    chk("w_f_fv", fv2, 1);
    chk("w_f_fa", fa2, 32'hFFFF_FFFC);
    tick();
    fdv2 = 1; fd2 = 32'h0000_0013;
    tick();
    fdv2 = 0;
    chk("w_i_iv", iv2, 1);
    chk("w_i_ia", ia2, 32'hFFFF_FFFC);
    chk("w_i_pca", pca2, 32'h0);
    chk("w_i_ins", ins2, 32'h0000_0013);
    tick();
    chk("w_n_fv", fv2, 1);
    chk("w_n_fa", fa2, 32'h0);
    chk("w_n_err", err2, 0);
    tick();
    chk("w_w_fv", fv2, 0);
    rst2 = 0;
    #1;
    chk("w_ar_fv", fv2, 0);
    chk("w_ar_fa", fa2, 32'hFFFF_FFFC);
    chk("w_ar_iv", iv2, 0);
    chk("w_ar_ia", ia2, 0);
    chk("w_ar_ins", ins2, 0);
    chk("w_ar_pca", pca2, 32'h0);
    rst2 = 1; fdv2 = 1; fd2 = 32'h77; fr2 = 0;
    tick(); tick();
    chk("w_late_fv", fv2, 1);
    chk("w_late_iv", iv2, 0);
    chk("w_late_fa", fa2, 32'hFFFF_FFFC);
    fdv2 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
